dbscan_region_query: RTL and testbench

//  Streaming point-cloud ingest plus exhaustive region query for the DBSCAN engine.
//  - Stores up to MAX_PTS 3-D points from a valid/last stream.
//  - Counts, for every stored point, the points within EPS, itself included.
//  - Flags core points and exposes a readback port for the downstream cluster-expansion stage.

---
 rtl/dbscan_pkg.sv | 13 +
 rtl/dbscan_dist.sv | 34 +++
 rtl/dbscan_region_query.sv | 175 +++++++++++++++++
 tb/tb_dbscan_region_query.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbscan_pkg.sv
// Shared types and constants for the DBSCAN ingest/region-query engine.
package dbscan_pkg;

  localparam int unsigned DIST_MANHATTAN = 0;
  localparam int unsigned DIST_CHEBYSHEV = 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dbscan_dist.sv
// Combinational neighbourhood test: is point b within EPS of point a?
module dbscan_dist
  import dbscan_pkg::*;
#(
  parameter int unsigned CW        = 8,
  parameter int unsigned EPS       = 10,
  parameter int unsigned DIST_MODE = DIST_MANHATTAN
) (
  input  logic [CW-1:0] i_ax,
  input  logic [CW-1:0] i_ay,
  input  logic [CW-1:0] i_az,
  input  logic [CW-1:0] i_bx,
  input  logic [CW-1:0] i_by,
  input  logic [CW-1:0] i_bz,
  output logic          o_in_eps
);

  logic [CW-1:0] w_dx, w_dy, w_dz;
  logic [CW+1:0] w_man;
  logic [CW-1:0] w_cheb_xy, w_cheb;

  assign w_dx = (i_ax > i_bx) ? i_ax - i_bx : i_bx - i_ax;
  assign w_dy = (i_ay > i_by) ? i_ay - i_by : i_by - i_ay;
  assign w_dz = (i_az > i_bz) ? i_az - i_bz : i_bz - i_az;

  // Sum is two bits wider than a coordinate so it can never wrap.
  assign w_man     = (CW+2)'(w_dx) + (CW+2)'(w_dy) + (CW+2)'(w_dz);
  assign w_cheb_xy = (w_dx > w_dy) ? w_dx : w_dy;
  assign w_cheb    = (w_cheb_xy > w_dz) ? w_cheb_xy : w_dz;

  assign o_in_eps = (DIST_MODE == DIST_CHEBYSHEV) ? (32'(w_cheb) <= 32'(EPS))
                                                  : (32'(w_man) <= 32'(EPS));

endmodule

// File: rtl/dbscan_region_query.sv
// Point-cloud frame ingest followed by an exhaustive all-pairs region query,
// with per-point neighbour counts and core flags exposed through a readback port.
module dbscan_region_query
  import dbscan_pkg::*;
#(
  parameter int unsigned CW        = 8,
  parameter int unsigned MAX_PTS   = 64,
  parameter int unsigned EPS       = 10,
  parameter int unsigned MIN_PTS   = 4,
  parameter int unsigned DIST_MODE = DIST_MANHATTAN,
  localparam int unsigned AW       = $clog2(MAX_PTS),
  localparam int unsigned CNTW     = $clog2(MAX_PTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   i_x,
  input  logic [CW-1:0]   i_y,
  input  logic [CW-1:0]   i_z,
  input  logic            i_in_valid,
  input  logic            i_in_last,
  output logic            o_in_ready,
  output logic            o_done,
  output logic [CNTW-1:0] o_num_points,
  output logic            o_overflow,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [CNTW-1:0] o_rd_count,
  output logic            o_rd_core
);

  state_t          r_state;
  logic [CW-1:0]   r_mem_x [MAX_PTS];
  logic [CW-1:0]   r_mem_y [MAX_PTS];
  logic [CW-1:0]   r_mem_z [MAX_PTS];
  logic [CNTW-1:0] r_cnt   [MAX_PTS];
  logic [CNTW-1:0] r_num_points;
  logic [AW-1:0]   r_i, r_j, r_hit_i;
  logic            r_hit, r_hit_vld, r_last_issued;
  logic            r_in_ready, r_done, r_overflow, r_rd_core;
  logic [CNTW-1:0] r_rd_count;

  logic            w_accept, w_room, w_wr_en, w_in_eps, w_i_end, w_j_end, w_rd_hit;
  logic [CNTW-1:0] w_np_next;
  logic [AW-1:0]   w_wr_addr;

  assign w_accept  = i_in_valid && r_in_ready;
  assign w_room    = r_num_points < CNTW'(MAX_PTS);
  assign w_np_next = w_room ? r_num_points + CNTW'(1) : r_num_points;
  assign w_i_end   = CNTW'(r_i) == r_num_points - CNTW'(1);
  assign w_j_end   = CNTW'(r_j) == r_num_points - CNTW'(1);
  assign w_rd_hit  = CNTW'(i_rd_addr) < r_num_points;

  // A beat accepted in DONE restarts the frame at slot 0.
  assign w_wr_en   = !rst && w_accept &&
                     ((r_state == ST_DONE) || (r_state == ST_LOAD && w_room));
  assign w_wr_addr = (r_state == ST_DONE) ? '0 : AW'(r_num_points);

  dbscan_dist #(
    .CW        (CW),
    .EPS       (EPS),
    .DIST_MODE (DIST_MODE)
  ) u_dist (
    .i_ax     (r_mem_x[r_i]),
    .i_ay     (r_mem_y[r_i]),
    .i_az     (r_mem_z[r_i]),
    .i_bx     (r_mem_x[r_j]),
    .i_by     (r_mem_y[r_j]),
    .i_bz     (r_mem_z[r_j]),
    .o_in_eps (w_in_eps)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_x[w_wr_addr] <= i_x;
      r_mem_y[w_wr_addr] <= i_y;
      r_mem_z[w_wr_addr] <= i_z;
    end
  end

  // The pair compare is registered, so counts land one cycle after issue and
  // DONE follows the final count update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_LOAD;
      r_in_ready    <= 1'b1;
      r_done        <= 1'b0;
      r_num_points  <= '0;
      r_overflow    <= 1'b0;
      r_rd_count    <= '0;
      r_rd_core     <= 1'b0;
      r_i           <= '0;
      r_j           <= '0;
      r_hit_i       <= '0;
      r_hit         <= 1'b0;
      r_hit_vld     <= 1'b0;
      r_last_issued <= 1'b0;
      for (int unsigned k = 0; k < MAX_PTS; k++) r_cnt[k] <= '0;
    end else begin
      r_rd_count <= '0;
      r_rd_core  <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_room) r_num_points <= w_np_next;
            else        r_overflow   <= 1'b1;
            if (i_in_last) begin
              r_i           <= '0;
              r_j           <= '0;
              r_hit_vld     <= 1'b0;
              r_last_issued <= 1'b0;
              if (w_np_next == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= ST_SCAN;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        ST_SCAN: begin
          if (r_hit_vld && r_hit) r_cnt[r_hit_i] <= r_cnt[r_hit_i] + CNTW'(1);
          r_hit_vld <= !r_last_issued;
          r_hit     <= w_in_eps;
          r_hit_i   <= r_i;
          if (!r_last_issued) begin
            if (w_j_end) begin
              r_j <= '0;
              if (w_i_end) r_last_issued <= 1'b1;
              else         r_i <= r_i + AW'(1);
            end else begin
              r_j <= r_j + AW'(1);
            end
          end else begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_accept) begin
            for (int unsigned k = 0; k < MAX_PTS; k++) r_cnt[k] <= '0;
            r_num_points <= CNTW'(1);
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            if (i_in_last) begin
              r_state       <= ST_SCAN;
              r_in_ready    <= 1'b0;
              r_i           <= '0;
              r_j           <= '0;
              r_hit_vld     <= 1'b0;
              r_last_issued <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (w_rd_hit) begin
            r_rd_count <= r_cnt[i_rd_addr];
            r_rd_core  <= 32'(r_cnt[i_rd_addr]) >= 32'(MIN_PTS);
          end
        end
        default: begin
          r_state    <= ST_LOAD;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_done       = r_done;
  assign o_num_points = r_num_points;
  assign o_overflow   = r_overflow;
  assign o_rd_count   = r_rd_count;
  assign o_rd_core    = r_rd_core;

endmodule

// File: tb/tb_dbscan_region_query.sv
// Directed bench: four parameterisations share one input stream; each test checks the relevant one.
module tb_dbscan_region_query;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = '0, y = '0, z = '0;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [5:0] rd_addr = '0;

  logic       d_ready, d_done, d_ovf, d_core;
  logic [6:0] d_np, d_cnt;
  logic       c_ready, c_done, c_ovf, c_core;
  logic [6:0] c_np, c_cnt;
  logic       m_ready, m_done, m_ovf, m_core;
  logic [6:0] m_np, m_cnt;
  logic       s_ready, s_done, s_ovf, s_core;
  logic [2:0] s_np, s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbscan_region_query u_dut (
    .clk(clk), .rst(rst), .i_x(x), .i_y(y), .i_z(z), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(d_ready), .o_done(d_done), .o_num_points(d_np), .o_overflow(d_ovf),
    .i_rd_addr(rd_addr), .o_rd_count(d_cnt), .o_rd_core(d_core));

  dbscan_region_query #(.EPS(4), .DIST_MODE(1)) u_cheb (
    .clk(clk), .rst(rst), .i_x(x), .i_y(y), .i_z(z), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(c_ready), .o_done(c_done), .o_num_points(c_np), .o_overflow(c_ovf),
    .i_rd_addr(rd_addr), .o_rd_count(c_cnt), .o_rd_core(c_core));

  dbscan_region_query #(.EPS(4), .DIST_MODE(0)) u_man4 (
    .clk(clk), .rst(rst), .i_x(x), .i_y(y), .i_z(z), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(m_ready), .o_done(m_done), .o_num_points(m_np), .o_overflow(m_ovf),
    .i_rd_addr(rd_addr), .o_rd_count(m_cnt), .o_rd_core(m_core));

  dbscan_region_query #(.MAX_PTS(4)) u_small (
    .clk(clk), .rst(rst), .i_x(x), .i_y(y), .i_z(z), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(s_ready), .o_done(s_done), .o_num_points(s_np), .o_overflow(s_ovf),
    .i_rd_addr(rd_addr[1:0]), .o_rd_count(s_cnt), .o_rd_core(s_core));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] px, input logic [7:0] py, input logic [7:0] pz,
                      input logic last);
    x = px; y = py; z = pz;
    in_valid = 1'b1;
    in_last = last;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame2();
    send(8'd10, 8'd10, 8'd10, 1'b0);
    send(8'd13, 8'd12, 8'd9,  1'b0);
    send(8'd8,  8'd15, 8'd11, 1'b0);
    send(8'd12, 8'd11, 8'd13, 1'b0);
    send(8'd9,  8'd14, 8'd8,  1'b0);
    send(8'd120, 8'd5, 8'd90, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) step();
    checks += 5;
    if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", d_ready); end
    if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d_done); end
    if (d_np !== 7'd0) begin errors++; $display("FAIL reset_num_points got %0d want 0", d_np); end
    if (d_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", d_ovf); end
    if (d_core !== 1'b0) begin errors++; $display("FAIL reset_rd_core got %b want 0", d_core); end
  endtask

  task automatic test_frame();
    int edges;
    logic [6:0] exp_cnt [6];
    logic       exp_core [6];
    exp_cnt  = '{7'd5, 7'd5, 7'd5, 7'd4, 7'd4, 7'd1};
    exp_core = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    send_frame2();
    checks++;
    if (d_np !== 7'd6) begin errors++; $display("FAIL frame_num_points got %0d want 6", d_np); end
    edges = 0;
    for (int e = 1; e <= 200; e++) begin
      step();
      if (d_done) begin edges = e; break; end
    end
    checks++;
    if (edges != 37) begin errors++; $display("FAIL frame_done_edge got %0d want 37", edges); end
    for (int k = 0; k < 6; k++) begin
      rd_addr = 6'(k);
      step();
      checks += 2;
      if (d_cnt !== exp_cnt[k]) begin
        errors++; $display("FAIL frame_count[%0d] got %0d want %0d", k, d_cnt, exp_cnt[k]);
      end
      if (d_core !== exp_core[k]) begin
        errors++; $display("FAIL frame_core[%0d] got %b want %b", k, d_core, exp_core[k]);
      end
    end
    rd_addr = 6'd6;
    step();
    checks += 2;
    if (d_cnt !== 7'd0) begin errors++; $display("FAIL frame_oob_count got %0d want 0", d_cnt); end
    if (d_core !== 1'b0) begin errors++; $display("FAIL frame_oob_core got %b want 0", d_core); end
    rd_addr = '0;
  endtask

  task automatic test_dist_mode();
    int edges;
    do_reset();
    send(8'd0, 8'd0, 8'd0, 1'b0);
    send(8'd4, 8'd4, 8'd4, 1'b1);
    edges = 0;
    for (int e = 1; e <= 50; e++) begin
      step();
      if (c_done) begin edges = e; break; end
    end
    checks++;
    if (edges != 5) begin errors++; $display("FAIL dist_done_edge got %0d want 5", edges); end
    for (int k = 0; k < 2; k++) begin
      rd_addr = 6'(k);
      step();
      checks += 2;
      if (c_cnt !== 7'd2) begin errors++; $display("FAIL cheb_count[%0d] got %0d want 2", k, c_cnt); end
      if (m_cnt !== 7'd1) begin errors++; $display("FAIL manh_count[%0d] got %0d want 1", k, m_cnt); end
    end
    rd_addr = '0;
  endtask

  task automatic test_overflow();
    int edges;
    do_reset();
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL ovf_in_ready[%0d] got %b want 1", b, s_ready); end
      send(8'd7, 8'd7, 8'd7, (b == 5));
    end
    checks += 2;
    if (s_np !== 3'd4) begin errors++; $display("FAIL ovf_num_points got %0d want 4", s_np); end
    if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", s_ovf); end
    edges = 0;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (s_done) begin edges = e; break; end
    end
    checks++;
    if (edges != 17) begin errors++; $display("FAIL ovf_done_edge got %0d want 17", edges); end
    rd_addr = 6'd3;
    step();
    checks += 2;
    if (s_cnt !== 3'd4) begin errors++; $display("FAIL ovf_count[3] got %0d want 4", s_cnt); end
    if (s_core !== 1'b1) begin errors++; $display("FAIL ovf_core[3] got %b want 1", s_core); end
    rd_addr = '0;
  endtask

  task automatic test_reset_mid_scan();
    int edges;
    do_reset();
    send_frame2();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 5;
    if (d_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", d_ready); end
    if (d_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", d_done); end
    if (d_np !== 7'd0) begin errors++; $display("FAIL abort_num_points got %0d want 0", d_np); end
    if (d_ovf !== 1'b0) begin errors++; $display("FAIL abort_overflow got %b want 0", d_ovf); end
    if (d_cnt !== 7'd0) begin errors++; $display("FAIL abort_rd_count got %0d want 0", d_cnt); end
    send(8'd1, 8'd2, 8'd3, 1'b1);
    edges = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (d_done) begin edges = e; break; end
    end
    checks++;
    if (edges != 2) begin errors++; $display("FAIL single_done_edge got %0d want 2", edges); end
    rd_addr = '0;
    step();
    checks += 2;
    if (d_cnt !== 7'd1) begin errors++; $display("FAIL single_count got %0d want 1", d_cnt); end
    if (d_core !== 1'b0) begin errors++; $display("FAIL single_core got %b want 0", d_core); end
  endtask

  task automatic test_back_to_back();
    int edges;
    do_reset();
    send_frame2();
    for (int e = 1; e <= 200; e++) begin
      step();
      if (d_done) break;
    end
    checks += 3;
    if (d_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", d_done); end
    if (d_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", d_ready); end
    if (s_ovf !== 1'b1) begin errors++; $display("FAIL b2b_small_ovf_before got %b want 1", s_ovf); end
    send(8'd50, 8'd50, 8'd50, 1'b0);
    checks += 4;
    if (d_done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got %b want 0", d_done); end
    if (d_np !== 7'd1) begin errors++; $display("FAIL b2b_num_points got %0d want 1", d_np); end
    if (d_ovf !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", d_ovf); end
    if (s_ovf !== 1'b0) begin errors++; $display("FAIL b2b_small_ovf_clear got %b want 0", s_ovf); end
    send(8'd51, 8'd50, 8'd50, 1'b1);
    edges = 0;
    for (int e = 1; e <= 50; e++) begin
      step();
      if (d_done) begin edges = e; break; end
    end
    checks++;
    if (edges != 5) begin errors++; $display("FAIL b2b_done_edge got %0d want 5", edges); end
    for (int k = 0; k < 2; k++) begin
      rd_addr = 6'(k);
      step();
      checks++;
      if (d_cnt !== 7'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", k, d_cnt); end
    end
    rd_addr = '0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_dist_mode();
    test_overflow();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
